// File: rtl/router_out_demux_pkg.sv
`default_nettype none
// ============================================================================
// router_out_demux_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the router output demultiplexer:
//   - one-hot FSM state encoding (IDLE / SEND / DROP)
//   - width of the one-hot destination-port field carried in TUSER
//   - multicast detection helper (more than one destination bit set)
// Revision: 1.0  initial release
// ============================================================================
package router_out_demux_pkg;

    localparam int DST_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_SEND = 3'b010,
        ST_DROP = 3'b100
    } state_e;

    // True when more than one bit of the destination mask is set.
    function automatic logic is_multicast(input logic [DST_W-1:0] mask);
        return (mask & (mask - DST_W'(1))) != '0;
    endfunction

endpackage : router_out_demux_pkg
`default_nettype wire

// File: rtl/router_out_demux_axis_skid_slice.sv
`default_nettype none
// ============================================================================
// axis_skid_slice
// ----------------------------------------------------------------------------
// Two-entry AXI4-Stream register slice. The output is driven directly from a
// register and the input ready depends only on local state, so there is no
// combinational path from i_out_ready to o_in_ready. Sustains one beat per
// cycle while the consumer keeps i_out_ready high.
//
// Ports
//   clk, resetn     clock, asynchronous active-low reset
//   i_in_data/valid upstream payload and valid
//   o_in_ready      upstream ready (low only while the skid entry is full)
//   o_out_data/valid downstream payload and valid (registered)
//   i_out_ready     downstream ready
// Revision: 1.0  initial release
// ============================================================================
module axis_skid_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic [W-1:0] i_in_data,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    output logic [W-1:0] o_out_data,
    output logic         o_out_valid,
    input  logic         i_out_ready
);

    logic [W-1:0] main_data_q, main_data_d;
    logic         main_valid_q, main_valid_d;
    logic [W-1:0] skid_data_q, skid_data_d;
    logic         skid_valid_q, skid_valid_d;

    logic         w_in_fire;
    logic         w_main_free;

    assign o_in_ready  = ~skid_valid_q;
    assign o_out_data  = main_data_q;
    assign o_out_valid = main_valid_q;

    assign w_in_fire   = i_in_valid & ~skid_valid_q;
    // The output register can take a new beat this cycle.
    assign w_main_free = ~main_valid_q | i_out_ready;

    always_comb begin
        main_data_d  = main_data_q;
        main_valid_d = main_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (w_main_free) begin
            if (skid_valid_q) begin
                // Input is blocked while the skid holds data, so only the
                // skid entry can refill the output register here.
                main_data_d  = skid_data_q;
                main_valid_d = 1'b1;
                skid_valid_d = 1'b0;
            end else if (w_in_fire) begin
                main_data_d  = i_in_data;
                main_valid_d = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (w_in_fire) begin
            skid_data_d  = i_in_data;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_data_q  <= '0;
            main_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            main_data_q  <= main_data_d;
            main_valid_q <= main_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

endmodule : axis_skid_slice
`default_nettype wire

// File: rtl/router_out_demux.sv
`default_nettype none
// ============================================================================
// router_out_demux
// ----------------------------------------------------------------------------
// Replicates each input AXI4-Stream packet to every output port selected by
// the one-hot destination byte in first-beat TUSER, or drains it when no port
// is selected. The first beat is peeked in IDLE (one decode cycle), then the
// packet is forwarded in lockstep to all selected per-port register slices.
// TUSER is held at the first-beat value for the whole packet.
//
// Ports
//   clk, resetn           clock, asynchronous active-low reset
//   S_AXIS_*              input stream (TUSER meaningful on first beat only)
//   M_AXIS_*              per-port output streams, port i in slice i
//   o_drop_busy           high while a packet is being drained
//   o_cnt_pkts_fwd/mcast/drop  packet counters (ROUTER_OUT_DEMUX_STATS_EN only)
//
// Optional feature macro: ROUTER_OUT_DEMUX_STATS_EN
// Revision: 1.0  initial release
// ============================================================================
module router_out_demux
    import router_out_demux_pkg::*;
#(
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DST_PORT_POS         = 24,
    parameter int NUM_PORTS            = 8
) (
    input  logic                                     clk,
    input  logic                                     resetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]           S_AXIS_TDATA,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]         S_AXIS_TSTRB,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]          S_AXIS_TUSER,
    input  logic                                     S_AXIS_TVALID,
    input  logic                                     S_AXIS_TLAST,
    output logic                                     S_AXIS_TREADY,
    output logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] M_AXIS_TUSER,
    output logic [NUM_PORTS-1:0]                     M_AXIS_TVALID,
    output logic [NUM_PORTS-1:0]                     M_AXIS_TLAST,
    input  logic [NUM_PORTS-1:0]                     M_AXIS_TREADY,
    output logic                                     o_drop_busy
`ifdef ROUTER_OUT_DEMUX_STATS_EN
   ,output logic [31:0]                              o_cnt_pkts_fwd,
    output logic [31:0]                              o_cnt_pkts_mcast,
    output logic [31:0]                              o_cnt_pkts_drop
`endif
);

    localparam int DW    = C_S_AXIS_DATA_WIDTH;
    localparam int SW    = C_S_AXIS_DATA_WIDTH / 8;
    localparam int UW    = C_S_AXIS_TUSER_WIDTH;
    localparam int PAY_W = DW + SW + UW + 1;

    state_e                 state_q, state_d;
    logic [NUM_PORTS-1:0]   r_mask_q, r_mask_d;
    logic [UW-1:0]          r_tuser_q, r_tuser_d;

    logic [DST_W-1:0]       w_dst;
    logic [NUM_PORTS-1:0]   w_mask;
    logic [NUM_PORTS-1:0]   w_skid_in_ready;
    logic [NUM_PORTS-1:0]   w_skid_in_valid;
    logic                   w_send_ready;
    logic                   w_send_fire;
    logic [PAY_W-1:0]       w_in_pay;
    logic [PAY_W-1:0]       w_out_pay [NUM_PORTS];

    assign w_dst  = S_AXIS_TUSER[DST_PORT_POS +: DST_W];
    // Destination bits above NUM_PORTS are ignored.
    assign w_mask = w_dst[NUM_PORTS-1:0];

    generate
        if (NUM_PORTS < DST_W) begin : g_dst_unused
            logic w_unused_dst;
            assign w_unused_dst = ^w_dst[DST_W-1:NUM_PORTS];
        end
    endgenerate

    // Lockstep: every selected slice must be able to accept the beat.
    // Non-selected ports are forced ready so they never stall the packet.
    assign w_send_ready = &(w_skid_in_ready | ~r_mask_q);
    assign w_send_fire  = (state_q == ST_SEND) & S_AXIS_TVALID & w_send_ready;

    always_comb begin
        state_d       = state_q;
        r_mask_d      = r_mask_q;
        r_tuser_d     = r_tuser_q;
        S_AXIS_TREADY = 1'b0;
        o_drop_busy   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // First beat is only inspected here; it is consumed in SEND.
                if (S_AXIS_TVALID) begin
                    if (w_mask == '0) begin
                        state_d = ST_DROP;
                    end else begin
                        r_mask_d  = w_mask;
                        r_tuser_d = S_AXIS_TUSER;
                        state_d   = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                S_AXIS_TREADY = w_send_ready;
                if (w_send_fire && S_AXIS_TLAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                S_AXIS_TREADY = 1'b1;
                o_drop_busy   = 1'b1;
                if (S_AXIS_TVALID && S_AXIS_TLAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            r_mask_q  <= '0;
            r_tuser_q <= '0;
        end else begin
            state_q   <= state_d;
            r_mask_q  <= r_mask_d;
            r_tuser_q <= r_tuser_d;
        end
    end

    assign w_in_pay = {S_AXIS_TLAST, r_tuser_q, S_AXIS_TSTRB, S_AXIS_TDATA};

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            assign w_skid_in_valid[i] = w_send_fire & r_mask_q[i];

            axis_skid_slice #(
                .W (PAY_W)
            ) u_skid (
                .clk         (clk),
                .resetn      (resetn),
                .i_in_data   (w_in_pay),
                .i_in_valid  (w_skid_in_valid[i]),
                .o_in_ready  (w_skid_in_ready[i]),
                .o_out_data  (w_out_pay[i]),
                .o_out_valid (M_AXIS_TVALID[i]),
                .i_out_ready (M_AXIS_TREADY[i])
            );

            assign M_AXIS_TDATA[i*DW +: DW] = w_out_pay[i][DW-1:0];
            assign M_AXIS_TSTRB[i*SW +: SW] = w_out_pay[i][DW +: SW];
            assign M_AXIS_TUSER[i*UW +: UW] = w_out_pay[i][DW+SW +: UW];
            assign M_AXIS_TLAST[i]          = w_out_pay[i][PAY_W-1];
        end
    endgenerate

`ifdef ROUTER_OUT_DEMUX_STATS_EN
    logic [31:0] cnt_fwd_q, cnt_fwd_d;
    logic [31:0] cnt_mcast_q, cnt_mcast_d;
    logic [31:0] cnt_drop_q, cnt_drop_d;

    always_comb begin
        cnt_fwd_d   = cnt_fwd_q;
        cnt_mcast_d = cnt_mcast_q;
        cnt_drop_d  = cnt_drop_q;
        if (state_q == ST_IDLE && S_AXIS_TVALID) begin
            if (w_mask == '0) begin
                cnt_drop_d = cnt_drop_q + 32'd1;
            end else begin
                cnt_fwd_d = cnt_fwd_q + 32'd1;
                if (is_multicast(DST_W'(w_mask))) begin
                    cnt_mcast_d = cnt_mcast_q + 32'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_fwd_q   <= '0;
            cnt_mcast_q <= '0;
            cnt_drop_q  <= '0;
        end else begin
            cnt_fwd_q   <= cnt_fwd_d;
            cnt_mcast_q <= cnt_mcast_d;
            cnt_drop_q  <= cnt_drop_d;
        end
    end

    assign o_cnt_pkts_fwd   = cnt_fwd_q;
    assign o_cnt_pkts_mcast = cnt_mcast_q;
    assign o_cnt_pkts_drop  = cnt_drop_q;
`endif

endmodule : router_out_demux
`default_nettype wire

// File: tb/tb_router_out_demux.sv
`default_nettype none
// ============================================================================
// tb_router_out_demux
// ----------------------------------------------------------------------------
// Scoreboard bench: the driver pushes the expected per-port beats when an
// input beat is accepted; an independent monitor pops and compares whenever a
// port transfers. A second, 4-port instance covers destination masking.
// Revision: 1.0  initial release
// ============================================================================
module tb_router_out_demux;

    localparam int DW  = 256;
    localparam int SW  = 32;
    localparam int UW  = 128;
    localparam int NP  = 8;
    localparam int DW4 = 32;
    localparam int UW4 = 32;
    localparam int NP4 = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [UW-1:0] u;
        logic          l;
    } beat_t;

    logic              clk = 1'b0;
    logic              resetn = 1'b0;
    logic [DW-1:0]     s_tdata = '0;
    logic [SW-1:0]     s_tstrb = '0;
    logic [UW-1:0]     s_tuser = '0;
    logic              s_tvalid = 1'b0;
    logic              s_tlast = 1'b0;
    logic              s_tready;
    logic [NP*DW-1:0]  m_tdata;
    logic [NP*SW-1:0]  m_tstrb;
    logic [NP*UW-1:0]  m_tuser;
    logic [NP-1:0]     m_tvalid;
    logic [NP-1:0]     m_tlast;
    logic [NP-1:0]     m_tready = '1;
    logic              drop_busy;

    logic [DW4-1:0]      s4_tdata = '0;
    logic [DW4/8-1:0]    s4_tstrb = '0;
    logic [UW4-1:0]      s4_tuser = '0;
    logic                s4_tvalid = 1'b0;
    logic                s4_tlast = 1'b0;
    logic                s4_tready;
    logic [NP4*DW4-1:0]  m4_tdata;
    logic [NP4*DW4/8-1:0] m4_tstrb;
    logic [NP4*UW4-1:0]  m4_tuser;
    logic [NP4-1:0]      m4_tvalid;
    logic [NP4-1:0]      m4_tlast;
    logic [NP4-1:0]      m4_tready = '1;
    logic                drop_busy4;

`ifdef ROUTER_OUT_DEMUX_STATS_EN
    logic [31:0] cnt_fwd, cnt_mcast, cnt_drop;
    logic [31:0] cnt4_fwd, cnt4_mcast, cnt4_drop;
`endif

    always #5 clk = ~clk;

    router_out_demux #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .DST_PORT_POS        (24),
        .NUM_PORTS           (NP)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TSTRB  (s_tstrb),
        .S_AXIS_TUSER  (s_tuser),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TSTRB  (m_tstrb),
        .M_AXIS_TUSER  (m_tuser),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .o_drop_busy   (drop_busy)
`ifdef ROUTER_OUT_DEMUX_STATS_EN
       ,.o_cnt_pkts_fwd  (cnt_fwd),
        .o_cnt_pkts_mcast(cnt_mcast),
        .o_cnt_pkts_drop (cnt_drop)
`endif
    );

    router_out_demux #(
        .C_S_AXIS_DATA_WIDTH (DW4),
        .C_S_AXIS_TUSER_WIDTH(UW4),
        .DST_PORT_POS        (24),
        .NUM_PORTS           (NP4)
    ) dut4 (
        .clk           (clk),
        .resetn        (resetn),
        .S_AXIS_TDATA  (s4_tdata),
        .S_AXIS_TSTRB  (s4_tstrb),
        .S_AXIS_TUSER  (s4_tuser),
        .S_AXIS_TVALID (s4_tvalid),
        .S_AXIS_TLAST  (s4_tlast),
        .S_AXIS_TREADY (s4_tready),
        .M_AXIS_TDATA  (m4_tdata),
        .M_AXIS_TSTRB  (m4_tstrb),
        .M_AXIS_TUSER  (m4_tuser),
        .M_AXIS_TVALID (m4_tvalid),
        .M_AXIS_TLAST  (m4_tlast),
        .M_AXIS_TREADY (m4_tready),
        .o_drop_busy   (drop_busy4)
`ifdef ROUTER_OUT_DEMUX_STATS_EN
       ,.o_cnt_pkts_fwd  (cnt4_fwd),
        .o_cnt_pkts_mcast(cnt4_mcast),
        .o_cnt_pkts_drop (cnt4_drop)
`endif
    );

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    beat_t exp_q [NP][$];
    int    lat_port = -1;
    int    lat_cyc = -1;
    int    pkt_start_cyc = 0;
    int    first_fire_cyc = 0;
    int    last_fire_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Drives one packet; returns early (TVALID left high) once stop_after
    // beats have been accepted, when stop_after >= 0.
    task automatic send_pkt(input logic [7:0] dst, input int nbeats,
                            input int stop_after, input logic [7:0] tag);
        logic [UW-1:0] u0;
        beat_t         e;
        bit            rdy;
        int            n;
        u0 = {{12{tag}}, dst, 8'h5A, tag, 8'h3C};
        pkt_start_cyc = cyc;
        for (int b = 0; b < nbeats; b++) begin
            if (stop_after >= 0 && b == stop_after) return;
            s_tvalid = 1'b1;
            s_tdata  = {8{tag, 8'(b), 16'hBEEF ^ 16'(b)}};
            s_tstrb  = (b == nbeats - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            s_tuser  = (b == 0) ? u0 : ~u0;
            s_tlast  = (b == nbeats - 1);
            n = 0;
            rdy = 1'b0;
            while (!rdy && n < 64) begin
                @(negedge clk);
                rdy = s_tready;
                if (rdy) begin
                    e.d = s_tdata;
                    e.s = s_tstrb;
                    e.u = u0;
                    e.l = s_tlast;
                    for (int p = 0; p < NP; p++)
                        if (dst[p]) exp_q[p].push_back(e);
                end
                @(posedge clk);
                #1;
                n++;
            end
            if (!rdy) check(1'b0, "drv_timeout", $sformatf("beat %0d never accepted, tready=%b", b, s_tready));
            if (b == 0) first_fire_cyc = cyc;
            last_fire_cyc = cyc;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    // Monitor: pops and compares whenever a port transfers a beat.
    initial begin
        beat_t got, e;
        forever begin
            @(negedge clk);
            if (resetn) begin
                for (int p = 0; p < NP; p++) begin
                    if (m_tvalid[p] && p == lat_port && lat_cyc < 0) lat_cyc = cyc;
                    if (m_tvalid[p] && m_tready[p]) begin
                        got.d = m_tdata[p*DW +: DW];
                        got.s = m_tstrb[p*SW +: SW];
                        got.u = m_tuser[p*UW +: UW];
                        got.l = m_tlast[p];
                        if (exp_q[p].size() == 0) begin
                            check(1'b0, $sformatf("port%0d_unexpected", p),
                                  $sformatf("got d=%h l=%b, expected no beat", got.d, got.l));
                        end else begin
                            e = exp_q[p].pop_front();
                            check(got === e, $sformatf("port%0d_beat", p),
                                  $sformatf("got d=%h u=%h s=%h l=%b exp d=%h u=%h s=%h l=%b",
                                            got.d, got.u, got.s, got.l, e.d, e.u, e.s, e.l));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int cnt;
        bit any_valid;
        int f1, f2;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check(s_tready == 1'b0, "rst_tready", $sformatf("got %b exp 0", s_tready));
        check(m_tvalid == '0, "rst_tvalid", $sformatf("got %b exp 0", m_tvalid));
        check(m_tdata == '0 && m_tuser == '0 && m_tstrb == '0 && m_tlast == '0, "rst_payload",
              $sformatf("got tlast=%b data_nonzero=%b", m_tlast, m_tdata != '0));
        check(drop_busy == 1'b0, "rst_drop_busy", $sformatf("got %b exp 0", drop_busy));
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Unicast to port 2, latency check
        lat_port = 2;
        lat_cyc  = -1;
        send_pkt(8'h04, 3, -1, 8'h11);
        repeat (4) @(posedge clk);
        #1;
        check(lat_cyc - pkt_start_cyc == 2, "unicast_latency",
              $sformatf("got %0d cycles exp 2", lat_cyc - pkt_start_cyc));
        lat_port = -1;

        // Multicast to ports 0 and 2 with port 2 stalled mid-packet
        fork
            send_pkt(8'h05, 4, -1, 8'h22);
            begin
                repeat (2) @(posedge clk);
                #1;
                m_tready[2] = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (i >= 1)
                        check(s_tready == 1'b0, "stall_tready",
                              $sformatf("stall cycle %0d got %b exp 0", i, s_tready));
                end
                @(posedge clk);
                #1;
                m_tready[2] = 1'b1;
            end
        join
        repeat (6) @(posedge clk);
        #1;

        // Drop of a 5-beat packet
        cnt = 0;
        any_valid = 1'b0;
        fork
            send_pkt(8'h00, 5, -1, 8'h33);
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                if (drop_busy && s_tready) cnt++;
                if (m_tvalid != '0) any_valid = 1'b1;
            end
        join
        check(cnt == 5, "drop_cycles", $sformatf("got %0d exp 5", cnt));
        check(!any_valid, "drop_no_output", $sformatf("got %b exp 0", any_valid));
        check(drop_busy == 1'b0, "drop_busy_end", $sformatf("got %b exp 0", drop_busy));
`ifdef ROUTER_OUT_DEMUX_STATS_EN
        check(cnt_drop == 32'd1, "stat_drop", $sformatf("got %0d exp 1", cnt_drop));
`endif

        // Back-to-back single-beat packets to ports 1 and 6
        send_pkt(8'h02, 1, -1, 8'h44);
        f1 = last_fire_cyc;
        send_pkt(8'h40, 1, -1, 8'h55);
        f2 = first_fire_cyc;
        check(f2 - f1 == 2, "b2b_gap", $sformatf("got %0d cycles between accepts exp 2", f2 - f1));
        repeat (4) @(posedge clk);
        #1;
`ifdef ROUTER_OUT_DEMUX_STATS_EN
        check(cnt_fwd == 32'd4, "stat_fwd", $sformatf("got %0d exp 4", cnt_fwd));
        check(cnt_mcast == 32'd1, "stat_mcast", $sformatf("got %0d exp 1", cnt_mcast));
`endif

        // Reset after beat 2 of a 4-beat packet to port 3
        send_pkt(8'h08, 4, 2, 8'h66);
        check(m_tvalid[3] == 1'b1, "prerst_valid3", $sformatf("got %b exp 1", m_tvalid[3]));
        #2;
        resetn = 1'b0;
        exp_q[3].delete();
        #1;
        check(m_tvalid == '0, "midrst_tvalid", $sformatf("got %b exp 0", m_tvalid));
        check(s_tready == 1'b0, "midrst_tready", $sformatf("got %b exp 0", s_tready));
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        send_pkt(8'h01, 2, -1, 8'h77);
        repeat (4) @(posedge clk);
        #1;
`ifdef ROUTER_OUT_DEMUX_STATS_EN
        check(cnt_fwd == 32'd1 && cnt_drop == 32'd0, "stat_after_rst",
              $sformatf("got fwd=%0d drop=%0d exp 1/0", cnt_fwd, cnt_drop));
`endif

        // 4-port instance: dst 8'h30 masks to zero and drains
        s4_tvalid = 1'b1;
        s4_tdata  = 32'hCAFE_0001;
        s4_tstrb  = 4'hF;
        s4_tuser  = 32'h3000_0000;
        s4_tlast  = 1'b0;
        @(negedge clk);
        check(s4_tready == 1'b0 && drop_busy4 == 1'b0, "n4_decode",
              $sformatf("got tready=%b busy=%b exp 0/0", s4_tready, drop_busy4));
        @(posedge clk);
        #1;
        s4_tdata = 32'hCAFE_0002;
        s4_tuser = 32'h0F00_0000;
        s4_tlast = 1'b1;
        @(negedge clk);
        check(s4_tready == 1'b1 && drop_busy4 == 1'b1, "n4_drop",
              $sformatf("got tready=%b busy=%b exp 1/1", s4_tready, drop_busy4));
        @(posedge clk);
        #1;
        s4_tvalid = 1'b0;
        s4_tlast  = 1'b0;
        @(negedge clk);
        check(drop_busy4 == 1'b0 && m4_tvalid == '0, "n4_no_output",
              $sformatf("got busy=%b tvalid=%b exp 0/0", drop_busy4, m4_tvalid));
`ifdef ROUTER_OUT_DEMUX_STATS_EN
        check(cnt4_drop == 32'd1 && cnt4_fwd == 32'd0, "n4_stats",
              $sformatf("got drop=%0d fwd=%0d exp 1/0", cnt4_drop, cnt4_fwd));
`endif
        repeat (3) @(posedge clk);
        #1;

        for (int p = 0; p < NP; p++)
            check(exp_q[p].size() == 0, $sformatf("port%0d_drained", p),
                  $sformatf("got %0d beats outstanding exp 0", exp_q[p].size()));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_router_out_demux
`default_nettype wire
